// File: rtl/output_fill_nd_if.sv
// Handshake, configuration and buffer-write bundle between the job issuer,
// the result FIFO, the output buffer and output_fill_nd.
interface output_fill_nd_if #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 14,
    parameter int CH_W   = 4
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_address;
    logic [DIM_W-1:0]  fm_width;
    logic [DIM_W-1:0]  fm_height;
    logic [CH_W-1:0]   num_channels;
    logic [ADDR_W-1:0] row_pitch;
    logic [ADDR_W-1:0] ch_pitch;
    logic              is_empty;
    logic              fifo_rd_en;
    logic [ADDR_W-1:0] c_address;
    logic              write_enable;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, base_address, fm_width, fm_height, num_channels,
               row_pitch, ch_pitch, is_empty,
        input  fifo_rd_en, c_address, write_enable, busy, done
    );

    modport slave (
        input  start, abort, base_address, fm_width, fm_height, num_channels,
               row_pitch, ch_pitch, is_empty,
        output fifo_rd_en, c_address, write_enable, busy, done
    );
endinterface

// File: rtl/output_fill_nd.sv
// Output-buffer fill controller: pops a result FIFO and walks a
// width x height x channel map, emitting registered write addresses/strobes.
module output_fill_nd #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 14,
    parameter int CH_W   = 4
) (
    input  logic                w_clk,
    input  logic                reset,
    output_fill_nd_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t            state_q;
    logic [DIM_W-1:0]  width_q;
    logic [DIM_W-1:0]  height_q;
    logic [CH_W-1:0]   chans_q;
    logic [ADDR_W-1:0] row_pitch_q;
    logic [ADDR_W-1:0] ch_pitch_q;
    logic [DIM_W-1:0]  col_q;
    logic [DIM_W-1:0]  row_q;
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] ch_base_q;
    logic [ADDR_W-1:0] c_address_q;
    logic              write_enable_q;
    logic              done_q;

    logic              pop;
    logic              last_col;
    logic              last_row;
    logic              last_ch;
    logic              zero_job;
    logic [ADDR_W-1:0] elem_addr;
    logic [ADDR_W-1:0] ch_base_d;
    logic [ADDR_W-1:0] row_base_d;

    assign pop      = (state_q == RUN) && !bus.is_empty && !bus.abort;
    assign last_col = (col_q == width_q - DIM_W'(1));
    assign last_row = (row_q == height_q - DIM_W'(1));
    assign last_ch  = (ch_q == chans_q - CH_W'(1));
    assign zero_job = (bus.fm_width == '0) || (bus.fm_height == '0) ||
                      (bus.num_channels == '0);

    // row_base_q already folds in the channel plane offset, so the element
    // address is a single add of the column index.
    always_comb begin
        elem_addr  = row_base_q + ADDR_W'(col_q);
        ch_base_d  = ch_base_q + ch_pitch_q;
        row_base_d = row_base_q + row_pitch_q;
    end

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            width_q        <= '0;
            height_q       <= '0;
            chans_q        <= '0;
            row_pitch_q    <= '0;
            ch_pitch_q     <= '0;
            col_q          <= '0;
            row_q          <= '0;
            ch_q           <= '0;
            row_base_q     <= '0;
            ch_base_q      <= '0;
            c_address_q    <= '0;
            write_enable_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            write_enable_q <= pop;
            done_q         <= 1'b0;
            if (pop) begin
                c_address_q <= elem_addr;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        width_q     <= bus.fm_width;
                        height_q    <= bus.fm_height;
                        chans_q     <= bus.num_channels;
                        row_pitch_q <= bus.row_pitch;
                        ch_pitch_q  <= bus.ch_pitch;
                        col_q       <= '0;
                        row_q       <= '0;
                        ch_q        <= '0;
                        row_base_q  <= bus.base_address;
                        ch_base_q   <= bus.base_address;
                        if (zero_job) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                    end else if (pop) begin
                        if (!last_col) begin
                            col_q <= col_q + DIM_W'(1);
                        end else begin
                            col_q <= '0;
                            if (!last_row) begin
                                row_q      <= row_q + DIM_W'(1);
                                row_base_q <= row_base_d;
                            end else begin
                                row_q <= '0;
                                if (!last_ch) begin
                                    ch_q       <= ch_q + CH_W'(1);
                                    ch_base_q  <= ch_base_d;
                                    row_base_q <= ch_base_d;
                                end else begin
                                    state_q <= LAST;
                                end
                            end
                        end
                    end
                end

                LAST: begin
                    state_q <= IDLE;
                    if (!bus.abort) begin
                        done_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en   = pop;
    assign bus.c_address    = c_address_q;
    assign bus.write_enable = write_enable_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
endmodule
